host_rx_display_seq: RTL and testbench

- Sequencer between the UART receiver and the 7-segment/LED display path of the host display design.
- Turns each received byte into display-buffer updates:
  - ordinary bytes shift into a 4-hex-digit buffer;
  - 0x0A clears it.
- Schedules an echo of every accepted byte onto the shared UART transmitter through a small FIFO and a start/busy handshake.

---
 rtl/host_rx_display_seq.sv | 169 ++++++++++++++++
 tb/tb_host_rx_display_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_rx_display_seq.sv
// UART-rx to display sequencer: hex-digit display buffer, LED mirror and echo scheduling.
// Optional feature macro: IDLE_CLEAR_EN (auto-clear the display after IDLE_CYCLES of silence).
module host_rx_display_seq #(
    parameter int unsigned ECHO_DEPTH  = 4,
    parameter int unsigned BUSY_WAIT   = 8,
    parameter int unsigned IDLE_CYCLES = 160000000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_blank,
    output logic [7:0]  leds,
    output logic        overflow
);

    localparam int unsigned AW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(ECHO_DEPTH + 1);
    localparam int unsigned WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WW-1:0]   wait_cnt;

    logic [7:0]      mem [ECHO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            accept;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            idle_hit;

    always_comb begin
        accept     = rx_valid & ~rx_error;
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(ECHO_DEPTH));
        pop        = (state == IDLE) && !fifo_empty && !tx_busy;
        // a pop frees the slot in the same cycle, so a full FIFO can still take the push
        push_ok    = accept && (!fifo_full || pop);
        drop       = accept && fifo_full && !pop;
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                tx_data <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + WW'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IDLE_CLEAR_EN
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    // saturates at IDLE_CYCLES so the clear fires once per quiet period
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(IDLE_CYCLES)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_comb idle_hit = !accept && (idle_cnt == IW'(IDLE_CYCLES - 1));
`else
    logic unused_idle_cfg;
    always_comb idle_hit = 1'b0;
    always_comb unused_idle_cfg = (IDLE_CYCLES != 0);
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            disp_value <= '0;
            disp_blank <= '1;
            leds       <= '0;
        end else if (accept) begin
            leds <= rx_data;
            if (rx_data == 8'h0A) begin
                disp_value <= '0;
                disp_blank <= '1;
            end else begin
                disp_value <= {disp_value[7:0], rx_data};
                disp_blank <= {disp_blank[1:0], 2'b00};
            end
        end else if (idle_hit) begin
            disp_value <= '0;
            disp_blank <= '1;
        end
    end

endmodule

// File: tb/tb_host_rx_display_seq.sv
// Directed plus randomized bench for host_rx_display_seq with a queue-based reference model.
module tb_host_rx_display_seq;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned BW     = 8;
    localparam int unsigned IDLE_N = 100;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [15:0] disp_value;
    logic [3:0]  disp_blank;
    logic [7:0]  leds;
    logic        overflow;

    logic        force_busy;
    logic        emu_en;
    logic        emu_busy = 1'b0;
    int unsigned emu_left = 0;

    always #5 clk_in = ~clk_in;
    always_comb tx_busy = force_busy | emu_busy;

    host_rx_display_seq #(
        .ECHO_DEPTH (DEPTH),
        .BUSY_WAIT  (BW),
        .IDLE_CYCLES(IDLE_N)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .disp_value(disp_value),
        .disp_blank(disp_blank),
        .leds      (leds),
        .overflow  (overflow)
    );

    // UART tx stand-in: goes busy for a random 1..4 cycles after each tx_start
    always @(posedge clk_in) begin
        if (emu_left != 0) begin
            emu_left <= emu_left - 1;
            if (emu_left == 1) emu_busy <= 1'b0;
        end else if (emu_en && tx_start === 1'b1 && rst === 1'b0) begin
            emu_busy <= 1'b1;
            emu_left <= $urandom_range(1, 4);
        end
    end

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } echo_t;

    echo_t       log_q[$];
    int unsigned cyc = 0;
    int unsigned wide_cnt = 0;
    int unsigned busy_viol = 0;
    logic        prev_start = 1'b0;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst === 1'b1) begin
            prev_start <= 1'b0;
        end else begin
            if (tx_start === 1'b1) begin
                log_q.push_back('{data: tx_data, cyc: cyc});
                if (prev_start) wide_cnt <= wide_cnt + 1;
                if (tx_busy === 1'b1) busy_viol <= busy_viol + 1;
            end
            prev_start <= tx_start;
        end
    end

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [7:0]  disp_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  leds_m;
    logic        ovf_m;
    int unsigned rd_idx = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model_value();
        case (disp_q.size())
            0:       return 16'h0000;
            1:       return {8'h00, disp_q[0]};
            default: return {disp_q[0], disp_q[1]};
        endcase
    endfunction

    function automatic logic [3:0] model_blank();
        case (disp_q.size())
            0:       return 4'b1111;
            1:       return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        int occ;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = err;
        if (!err) begin
            leds_m = b;
            if (b == 8'h0A) begin
                disp_q.delete();
            end else begin
                disp_q.push_back(b);
                if (disp_q.size() > 2) void'(disp_q.pop_front());
            end
            occ = int'(exp_q.size()) - int'(log_q.size());
            if (occ >= int'(DEPTH)) ovf_m = 1'b1;
            else exp_q.push_back(b);
        end
        step();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " value"}, disp_value, model_value());
        chk({tag, " blank"}, 16'(disp_blank), 16'(model_blank()));
        chk({tag, " leds"}, 16'(leds), 16'(leds_m));
        chk({tag, " ovf"}, 16'(overflow), 16'(ovf_m));
    endtask

    task automatic wait_echoes(input string tag);
        for (int i = 0; i < 300 && log_q.size() < exp_q.size(); i++) step();
        chk({tag, " echo count"}, 16'(log_q.size()), 16'(exp_q.size()));
        while (rd_idx < log_q.size() && rd_idx < exp_q.size()) begin
            chk({tag, " echo data"}, 16'(log_q[rd_idx].data), 16'(exp_q[rd_idx]));
            rd_idx++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " disp_value"}, disp_value, 16'h0000);
        chk({tag, " disp_blank"}, 16'(disp_blank), 16'h000F);
        chk({tag, " leds"}, 16'(leds), 16'h0000);
        chk({tag, " tx_data"}, 16'(tx_data), 16'h0000);
        chk({tag, " tx_start"}, 16'(tx_start), 16'h0000);
        chk({tag, " overflow"}, 16'(overflow), 16'h0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        logic        e;
        int unsigned base;
        int unsigned gap;

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0;
        force_busy = 1'b0; emu_en = 1'b1;
        leds_m = '0; ovf_m = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        send(8'hD9, 1'b0);
        chk("echo latency", 16'(tx_start), 16'h0000);
        check_state("d9");
        send(8'h32, 1'b0);
        check_state("32");
        chk("d932 literal", disp_value, 16'hD932);
        wait_echoes("d9_32");

        send(8'h0A, 1'b0);
        check_state("0a");
        send(8'hA3, 1'b0);
        check_state("a3");
        send(8'h21, 1'b0);
        check_state("21");
        chk("a321 literal", disp_value, 16'hA321);
        send(8'h55, 1'b0);
        check_state("55");
        send(8'h77, 1'b1);
        check_state("rx_error");
        wait_echoes("directed");

        // no tx_busy response: each echo is abandoned after BUSY_WAIT cycles
        repeat (10) step();
        emu_en = 1'b0;
        base = log_q.size();
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        for (int i = 0; i < 100 && log_q.size() < base + 2; i++) step();
        chk("timeout echoes", 16'(log_q.size() - base), 16'h0002);
        if (log_q.size() >= base + 2) begin
            gap = log_q[base + 1].cyc - log_q[base].cyc;
            chk("timeout gap", 16'(gap >= BW + 1 && gap <= BW + 3), 16'h0001);
        end
        wait_echoes("timeout");
        repeat (15) step();
        emu_en = 1'b1;

        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b = 8'h0A;
            e = ($urandom_range(0, 7) == 0);
            send(b, e);
            check_state("random");
            repeat ($urandom_range(8, 15)) step();
        end
        wait_echoes("random");
        repeat (10) step();

        force_busy = 1'b1;
        step();
        for (int v = 1; v <= 6; v++) send(8'(v), 1'b0);
        check_state("overflow");
        chk("overflow literal", disp_value, 16'h0506);
        chk("overflow flag", 16'(overflow), 16'h0001);
        repeat (3) step();
        chk("no echo while busy", 16'(log_q.size()), 16'(rd_idx));
        force_busy = 1'b0;
        wait_echoes("overflow");
        repeat (10) step();

        emu_en = 1'b0;
        base = log_q.size();
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        send(8'h5C, 1'b0);
        for (int i = 0; i < 50 && log_q.size() < base + 1; i++) step();
        chk("pre-reset echo", 16'(log_q.size() - base), 16'h0001);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        disp_q.delete(); leds_m = '0; ovf_m = 1'b0;
        while (exp_q.size() > log_q.size()) void'(exp_q.pop_back());
        rd_idx = log_q.size();
        step();
        rst = 1'b0;
        emu_en = 1'b1;
        repeat (30) step();
        chk("fifo flushed by reset", 16'(log_q.size()), 16'(exp_q.size()));
        check_state("after reset");

`ifdef IDLE_CLEAR_EN
        send(8'h12, 1'b0);
        repeat (IDLE_N - 10) step();
        chk("idle not yet", disp_value, 16'h0012);
        repeat (20) step();
        chk("idle clear value", disp_value, 16'h0000);
        chk("idle clear blank", 16'(disp_blank), 16'h000F);
        chk("idle clear leds", 16'(leds), 16'h0012);
        wait_echoes("idle");
`endif

        repeat (30) step();
        chk("no extra echoes", 16'(log_q.size()), 16'(exp_q.size()));
        chk("tx_start width", 16'(wide_cnt), 16'h0000);
        chk("tx_start while busy", 16'(busy_viol), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
